// File: rtl/ccff_chain_loader.sv
// Configuration-chain master: serialises bitstream words MSB-first onto ccff_head
// and packs the displaced chain contents from ccff_tail into readback words.
module ccff_chain_loader #(
    parameter int WORD_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  chain_len,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
);

    localparam int BC_W = $clog2(WORD_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [BC_W-1:0] FULL = BC_W'(WORD_W);

    // Partial readback words leave left-aligned with zero padding below.
    function automatic logic [WORD_W-1:0] left_align(input logic [WORD_W-1:0] w,
                                                     input logic [BC_W-1:0]   n);
        return w << (FULL - n);
    endfunction

    logic [1:0]        state_q,   state_d;
    logic [LEN_W-1:0]  rem_q,     rem_d;
    logic [WORD_W-1:0] buf_q,     buf_d;
    logic [BC_W-1:0]   bc_q,      bc_d;
    logic [WORD_W-1:0] rb_q,      rb_d;
    logic [BC_W-1:0]   rb_cnt_q,  rb_cnt_d;
    logic [WORD_W-1:0] m_data_q,  m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q,  m_last_d;

    logic              in_shift;
    logic              slot_free;
    logic              rb_full;
    logic              shift;
    logic              accept;
    logic              last_bit;
    logic [WORD_W-1:0] rb_next;
    logic [BC_W-1:0]   rb_cnt_next;

    assign in_shift    = (state_q == ST_SHIFT);
    assign slot_free   = !m_valid_q || m_ready;
    assign rb_full     = (rb_cnt_q == FULL);
    // Stall only when a word is pending downstream and the capture register is full too.
    assign shift       = in_shift && (bc_q != '0) && !(m_valid_q && !m_ready && rb_full);
    assign s_ready     = in_shift && (rem_q > LEN_W'(bc_q))
                         && ((bc_q == '0) || ((bc_q == BC_W'(1)) && shift));
    assign accept      = s_valid && s_ready;
    assign last_bit    = shift && (rem_q == LEN_W'(1));
    assign rb_next     = {rb_q[WORD_W-2:0], ccff_tail};
    assign rb_cnt_next = rb_cnt_q + 1'b1;

    always_comb begin
        // NOTE: every next-state signal starts from its held value so no path infers a latch.
        state_d   = state_q;
        rem_d     = rem_q;
        buf_d     = buf_q;
        bc_d      = bc_q;
        rb_d      = rb_q;
        rb_cnt_d  = rb_cnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rb_cnt_d = '0;
                    if (chain_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        rem_d   = chain_len;
                        state_d = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                if (shift) begin
                    buf_d = buf_q << 1;
                    bc_d  = bc_q - 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rb_full) begin
                        // The held full word moves out as the new bit starts the next word.
                        m_data_d  = rb_q;
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b0;
                        rb_d      = {{(WORD_W-1){1'b0}}, ccff_tail};
                        rb_cnt_d  = BC_W'(1);
                    end else begin
                        rb_d     = rb_next;
                        rb_cnt_d = rb_cnt_next;
                        if (slot_free && ((rb_cnt_next == FULL) || last_bit)) begin
                            m_data_d  = left_align(rb_next, rb_cnt_next);
                            m_valid_d = 1'b1;
                            m_last_d  = last_bit;
                            rb_cnt_d  = '0;
                        end
                    end
                end else if (rb_full && slot_free) begin
                    m_data_d  = rb_q;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    rb_cnt_d  = '0;
                end

                if (accept) begin
                    buf_d = s_data;
                    bc_d  = FULL;
                end

                if (last_bit) begin
                    bc_d    = '0;
                    state_d = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                if (rb_cnt_q != '0) begin
                    if (slot_free) begin
                        m_data_d  = left_align(rb_q, rb_cnt_q);
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b1;
                        rb_cnt_d  = '0;
                    end
                end else if (slot_free) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d   = ST_IDLE;
            bc_d      = '0;
            rb_cnt_d  = '0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            buf_q     <= '0;
            bc_q      <= '0;
            rb_q      <= '0;
            rb_cnt_q  <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            buf_q     <= buf_d;
            bc_q      <= bc_d;
            rb_q      <= rb_d;
            rb_cnt_q  <= rb_cnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_data        = m_data_q;
    assign m_valid       = m_valid_q;
    assign m_last        = m_last_q;
    assign ccff_head     = (bc_q != '0) && buf_q[WORD_W-1];
    assign ccff_shift_en = shift;
    assign busy          = (state_q == ST_SHIFT) || (state_q == ST_FLUSH);
    assign done          = (state_q == ST_DONE);

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain master for the FPGA fabric. It takes bitstream words from the secure-bitstream datapath and serialises them, MSB first, onto the head of a tile configuration chain (`ccff_head`). It drives the chain shift enable. In the same cycles it captures the bits leaving the chain tail (`ccff_tail`), which are the previous contents, and packs them into readback words for integrity checking. It sits between the bitstream decrypt/authenticate logic and the top-level `ccff_head`/`ccff_tail` of the fabric.

## Interface
- `WORD_W`, 8, width of bitstream and readback words (≥2)
- `LEN_W`, 16, width of the chain-length count
- `prog_clk`  in  1  programming clock; all state on rising edge
- `pReset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request, honoured only in IDLE
- `abort`  in  1  synchronous cancel, any state
- `chain_len`  in  LEN_W  number of bits to shift, sampled on `start`
- `s_data`  in  WORD_W  bitstream word
- `s_valid` / `s_ready`  in/out  1  bitstream handshake
- `m_data`  out  WORD_W  readback word
- `m_last`  out  1  marks the final readback word
- `m_valid` / `m_ready`  out/in  1  readback handshake
- `ccff_head`  out  1  serial data into chain
- `ccff_shift_en`  out  1  chain clock-enable; chain shifts on the edge where this is 1
- `ccff_tail`  in  1  serial data out of chain
- `busy`  out  1  high in SHIFT/FLUSH
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SHIFT, FLUSH, DONE.
- IDLE: on `start` with `chain_len`≠0, latch rem=`chain_len` and go to SHIFT. On `start` with `chain_len`=0, go to DONE directly; no shift and no readback word.
- Input buffer holds one word plus bc (bits held).
  - `s_ready` = SHIFT && rem>bc && (bc==0 || (bc==1 && shift)).
  - On accept: buffer ← `s_data`, bc ← WORD_W.
- shift = SHIFT && bc>0 && !(`m_valid` && !`m_ready` && rb_cnt==WORD_W).
- `ccff_head` = buffer MSB (0 when bc=0). `ccff_shift_en` = shift. Both are combinational from registered state plus `m_ready`.
- On each shift:
  - buffer shifts left; bc−1; rem−1.
  - `ccff_tail` is shifted into the readback register LSB; rb_cnt+1.
- rb_cnt reaching WORD_W loads `m_data`, sets `m_valid` and clears rb_cnt.
- When rem reaches 0:
  - unused buffer bits are discarded (bc←0).
  - If rb_cnt>0, the partial word goes out left-aligned and zero-padded.
  - The final word carries `m_last`=1.
  - Go to FLUSH.
- FLUSH: hold `m_valid` until `m_ready`, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `m_valid` stays high with `m_data` stable until `m_ready`. Only one word is pending; the readback register continues to fill while a word is pending, and shifting stalls only when both are full.
- `abort`: next state IDLE; clears bc, rb_cnt and `m_valid`; no `done`. The chain holds partially shifted data.
- `start` outside IDLE is ignored.

## Timing
- Reset values: `s_ready`, `m_valid`, `m_last`, `m_data`, `ccff_head`, `ccff_shift_en`, `busy`, `done` all 0; state IDLE.
- Full throughput is 1 bit per cycle with `s_valid` and `m_ready` held high. There are no bubbles at word boundaries.
- Cycle timeline:
  - `start` at cycle 0.
  - First `s_ready` at cycle 1.
  - First shift at cycle 2.
- Readback word latency: `m_valid` rises the cycle after the shift that captured the WORD_W-th bit.
- `done` timing:
  - with `m_ready` held high, `done` occurs 2 cycles after the final shift;
  - for `chain_len`=0, `done` occurs 1 cycle after `start`.
- Asynchronous reset mid-shift returns all outputs to reset values immediately. No further `ccff_shift_en`.

## Test plan
- WORD_W=8, `chain_len`=16, words 0xA5,0x3C, chain pre-filled 0xFFFF, `m_ready`=1 → 16 consecutive `ccff_shift_en` cycles; head sequence 1010010100111100; readback 0xFF, then 0xFF with `m_last`; one `done`.
- `chain_len`=12, words 0xF0,0x9A, chain pre-filled 0x5A5 → 12 shifts, head bits 1111_0000_1001; readback 0x5A then 0x50 (`m_last`); low nibble of 0x9A discarded; `s_ready` never high a third time.
- `m_ready`=0 for 20 cycles during a 16-bit load → shifting stalls after 16 bits captured with one word pending; resumes within 1 cycle of `m_ready`; no bit lost or duplicated.
- `s_valid` gaps of 3 cycles between words → `ccff_shift_en` low during gaps; `ccff_head` stream identical to the gap-free case.
- `abort` after 5 shifts → next cycle IDLE, `busy`=0, `m_valid`=0, no `done`. A subsequent `start` with `chain_len`=8 completes normally.
- `chain_len`=0 → `done` at cycle 1, zero `ccff_shift_en`, no `m_valid`. `pReset_n` low mid-load → all outputs 0 asynchronously.
